// File: rtl/alu_issue_stage_pkg.sv
// Shared encodings for the ALU issue stage: funct codes, ALU op selects and
// the decoded-control record carried through stage 1.
package alu_issue_stage_pkg;
  localparam int DATA_W = 16;

  typedef enum logic [3:0] {
    F_AND = 4'h0,
    F_OR  = 4'h1,
    F_ADD = 4'h2,
    F_SUB = 4'h3,
    F_SLT = 4'h4,
    F_XOR = 4'h5,
    F_CMP = 4'h6
  } funct_e;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SLT = 3'b011,
    OP_XOR = 3'b100
  } alu_op_e;

  // Flag-mask bit order: {Z, V, C}
  localparam logic [2:0] FM_NONE = 3'b000;
  localparam logic [2:0] FM_Z    = 3'b100;
  localparam logic [2:0] FM_ZVC  = 3'b111;

  typedef struct packed {
    alu_op_e    op;
    logic       bnegate;
    logic       we;
    logic [2:0] fmask;
  } ctrl_t;

  function automatic ctrl_t mk_ctrl(alu_op_e op, logic bn, logic we, logic [2:0] fm);
    ctrl_t c;
    c.op      = op;
    c.bnegate = bn;
    c.we      = we;
    c.fmask   = fm;
    return c;
  endfunction
endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream, ALU and writeback signals of the issue stage; slave is the stage side.
interface alu_issue_stage_if #(parameter int WIDTH = 16);
  logic             in_valid, in_ready;
  logic [3:0]       in_funct;
  logic [WIDTH-1:0] in_a, in_b;
  logic [2:0]       in_dest;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [2:0]       alu_op;
  logic             alu_bnegate;
  logic [WIDTH-1:0] alu_rez;
  logic             alu_zero, alu_overflow, alu_carry;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_result;
  logic [2:0]       out_dest;
  logic             out_we;
  logic             flag_z, flag_v, flag_c, illegal_err;

  modport slave (
    input  in_valid, in_funct, in_a, in_b, in_dest,
           alu_rez, alu_zero, alu_overflow, alu_carry, out_ready,
    output in_ready, alu_a, alu_b, alu_op, alu_bnegate,
           out_valid, out_result, out_dest, out_we,
           flag_z, flag_v, flag_c, illegal_err
  );

  modport master (
    output in_valid, in_funct, in_a, in_b, in_dest,
           alu_rez, alu_zero, alu_overflow, alu_carry, out_ready,
    input  in_ready, alu_a, alu_b, alu_op, alu_bnegate,
           out_valid, out_result, out_dest, out_we,
           flag_z, flag_v, flag_c, illegal_err
  );
endinterface

// File: rtl/alu_funct_decode.sv
// Combinational funct decoder: control record plus illegal-code flag.
module alu_funct_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [3:0] i_funct,
  output ctrl_t      o_ctrl,
  output logic       o_illegal
);
  always_comb begin
    o_ctrl    = '0;
    o_illegal = 1'b0;
    case (funct_e'(i_funct))
      F_AND:   o_ctrl = mk_ctrl(OP_AND, 1'b0, 1'b1, FM_Z);
      F_OR:    o_ctrl = mk_ctrl(OP_OR,  1'b0, 1'b1, FM_Z);
      F_ADD:   o_ctrl = mk_ctrl(OP_ADD, 1'b0, 1'b1, FM_ZVC);
      F_SUB:   o_ctrl = mk_ctrl(OP_ADD, 1'b1, 1'b1, FM_ZVC);
      F_SLT:   o_ctrl = mk_ctrl(OP_SLT, 1'b1, 1'b1, FM_NONE);
      F_XOR:   o_ctrl = mk_ctrl(OP_XOR, 1'b0, 1'b1, FM_Z);
      F_CMP:   o_ctrl = mk_ctrl(OP_ADD, 1'b1, 1'b0, FM_ZVC);
      default: o_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage ALU issue pipeline: S1 drives the external ALU, S2 holds writeback.
// Flags are committed on the S1->S2 transfer.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  alu_issue_stage_if.slave  bus
);
  ctrl_t w_ctrl;
  logic  w_illegal;

  alu_funct_decode u_dec (
    .i_funct   (bus.in_funct),
    .o_ctrl    (w_ctrl),
    .o_illegal (w_illegal)
  );

  logic [2:1]       r_vld_pipe;
  ctrl_t            r_s1_ctrl;
  logic [WIDTH-1:0] r_a, r_b;
  logic [2:0]       r_s1_dest;
  logic [WIDTH-1:0] r_res;
  logic [2:0]       r_s2_dest;
  logic             r_s2_we;
  logic             r_fz, r_fv, r_fc, r_err;

  logic w_s2_adv, w_in_ready, w_acc, w_load;

  assign w_s2_adv   = r_vld_pipe[1] && (!r_vld_pipe[2] || bus.out_ready);
  assign w_in_ready = !r_vld_pipe[1] || w_s2_adv;
  assign w_acc      = bus.in_valid && w_in_ready;
  // Illegal codes are handshaken normally but never occupy S1.
  assign w_load     = w_acc && !w_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_s1_ctrl  <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_s1_dest  <= '0;
      r_res      <= '0;
      r_s2_dest  <= '0;
      r_s2_we    <= 1'b0;
      r_fz       <= 1'b0;
      r_fv       <= 1'b0;
      r_fc       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_load) begin
        r_s1_ctrl <= w_ctrl;
        r_a       <= bus.in_a;
        r_b       <= bus.in_b;
        r_s1_dest <= bus.in_dest;
      end
      if (w_load)        r_vld_pipe[1] <= 1'b1;
      else if (w_s2_adv) r_vld_pipe[1] <= 1'b0;

      if (w_s2_adv) begin
        r_vld_pipe[2] <= 1'b1;
        r_res         <= bus.alu_rez;
        r_s2_dest     <= r_s1_dest;
        r_s2_we       <= r_s1_ctrl.we;
        if (r_s1_ctrl.fmask[2]) r_fz <= bus.alu_zero;
        if (r_s1_ctrl.fmask[1]) r_fv <= bus.alu_overflow;
        if (r_s1_ctrl.fmask[0]) r_fc <= bus.alu_carry;
      end else if (bus.out_ready) begin
        r_vld_pipe[2] <= 1'b0;
      end

      if (w_acc && w_illegal) r_err <= 1'b1;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.alu_a       = r_a;
  assign bus.alu_b       = r_b;
  assign bus.alu_op      = r_s1_ctrl.op;
  assign bus.alu_bnegate = r_s1_ctrl.bnegate;
  assign bus.out_valid   = r_vld_pipe[2];
  assign bus.out_result  = r_res;
  assign bus.out_dest    = r_s2_dest;
  assign bus.out_we      = r_s2_we;
  assign bus.flag_z      = r_fz;
  assign bus.flag_v      = r_fv;
  assign bus.flag_c      = r_fc;
  assign bus.illegal_err = r_err;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural external ALU.
module tb_alu_issue_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_issue_stage_if #(.WIDTH(16)) bus ();

  alu_issue_stage #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // External ALU: add/sub share one adder, B inverted with carry-in on bnegate.
  logic [15:0] m_bb;
  logic [16:0] m_sum;
  always_comb begin
    m_bb  = bus.alu_bnegate ? ~bus.alu_b : bus.alu_b;
    m_sum = {1'b0, bus.alu_a} + {1'b0, m_bb} + {16'd0, bus.alu_bnegate};
    case (bus.alu_op)
      3'b000:  bus.alu_rez = bus.alu_a & bus.alu_b;
      3'b001:  bus.alu_rez = bus.alu_a | bus.alu_b;
      3'b010:  bus.alu_rez = m_sum[15:0];
      3'b011:  bus.alu_rez = {15'd0, ($signed(bus.alu_a) < $signed(bus.alu_b))};
      3'b100:  bus.alu_rez = bus.alu_a ^ bus.alu_b;
      default: bus.alu_rez = 16'd0;
    endcase
    bus.alu_zero     = (bus.alu_rez == 16'd0);
    bus.alu_carry    = m_sum[16];
    bus.alu_overflow = (bus.alu_a[15] == m_bb[15]) && (m_sum[15] != bus.alu_a[15]);
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  int          n_acc, n_out;
  logic [15:0] q_res[$];
  always @(negedge clk) begin
    if (bus.in_valid && bus.in_ready) n_acc++;
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      q_res.push_back(bus.out_result);
    end
  end

  function automatic logic [15:0] qget(input int k);
    return (q_res.size() > k) ? q_res[k] : 16'hDEAD;
  endfunction

  task automatic drive(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] d);
    bus.in_valid = 1'b1;
    bus.in_funct = f;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_dest  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    n_acc = 0;
    n_out = 0;
    q_res.delete();
  endtask

  typedef struct {
    logic [3:0]  funct;
    logic [15:0] a, b;
    logic [2:0]  dest;
    logic [2:0]  op;
    logic        bneg;
    logic [15:0] res;
    logic        chk_res;
    logic        we;
    logic        z, v, c;
  } vec_t;

  vec_t vt[9];

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    //          funct  a         b         dst   op      bn    res       chk   we    Z     V     C
    vt[0] = '{4'h2, 16'h7FFF, 16'h0001, 3'd1, 3'b010, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[1] = '{4'h3, 16'h0005, 16'h0005, 3'd2, 3'b010, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[2] = '{4'h0, 16'h0F0F, 16'hF0F0, 3'd3, 3'b000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[3] = '{4'h1, 16'h0001, 16'h0000, 3'd4, 3'b001, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[4] = '{4'h4, 16'hFFFF, 16'h0001, 3'd5, 3'b011, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[5] = '{4'h5, 16'hAAAA, 16'hAAAA, 3'd6, 3'b100, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[6] = '{4'h6, 16'h0003, 16'h0004, 3'd7, 3'b010, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7] = '{4'h2, 16'hFFFF, 16'h0001, 3'd0, 3'b010, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[8] = '{4'h2, 16'h8000, 16'h8000, 3'd1, 3'b010, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    bus.in_valid  = 1'b0;
    bus.in_funct  = 4'h0;
    bus.in_a      = 16'h0;
    bus.in_b      = 16'h0;
    bus.in_dest   = 3'd0;
    bus.out_ready = 1'b1;
    clr_mon();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_alu_a", bus.alu_a, 16'h0);
    chk("rst_out_result", bus.out_result, 16'h0);
    chk("rst_flags", {bus.flag_z, bus.flag_v, bus.flag_c}, 3'b000);
    chk("rst_illegal", bus.illegal_err, 1'b0);

    // Table: one operation at a time, full-rate output.
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("v%0d_in_ready", i), bus.in_ready, 1'b1);
      drive(vt[i].funct, vt[i].a, vt[i].b, vt[i].dest);
      tick();
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d_alu_op", i), bus.alu_op, vt[i].op);
      chk($sformatf("v%0d_alu_bneg", i), bus.alu_bnegate, vt[i].bneg);
      chk($sformatf("v%0d_alu_ab", i), {bus.alu_a, bus.alu_b}, {vt[i].a, vt[i].b});
      chk($sformatf("v%0d_early_valid", i), bus.out_valid, 1'b0);
      tick();
      chk($sformatf("v%0d_out_valid", i), bus.out_valid, 1'b1);
      if (vt[i].chk_res) chk($sformatf("v%0d_result", i), bus.out_result, vt[i].res);
      chk($sformatf("v%0d_dest", i), bus.out_dest, vt[i].dest);
      chk($sformatf("v%0d_we", i), bus.out_we, vt[i].we);
      chk($sformatf("v%0d_flags", i), {bus.flag_z, bus.flag_v, bus.flag_c},
          {vt[i].z, vt[i].v, vt[i].c});
    end
    tick();

    // Backpressure: two accepted, third stalls until release.
    clr_mon();
    bus.out_ready = 1'b0;
    drive(4'h2, 16'd1, 16'd1, 3'd1);
    tick();
    drive(4'h2, 16'd2, 16'd2, 3'd2);
    tick();
    drive(4'h2, 16'd3, 16'd3, 3'd3);
    chk("bp_in_ready_full", bus.in_ready, 1'b0);
    repeat (3) tick();
    chk("bp_in_ready_hold", bus.in_ready, 1'b0);
    chk("bp_acc_count", n_acc, 2);
    chk("bp_alu_a_steady", bus.alu_a, 16'd2);
    chk("bp_out_stable", {bus.out_valid, bus.out_result, bus.out_dest}, {1'b1, 16'd2, 3'd1});
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10 && bus.in_valid; k++) begin
      tick();
      if (n_acc == 3) bus.in_valid = 1'b0;
    end
    chk("bp_third_accepted", bus.in_valid, 1'b0);
    bus.in_valid = 1'b0;
    repeat (4) tick();
    chk("bp_out_count", n_out, 3);
    chk("bp_res0", qget(0), 16'd2);
    chk("bp_res1", qget(1), 16'd4);
    chk("bp_res2", qget(2), 16'd6);

    // Illegal funct between two ADDs.
    clr_mon();
    chk("ill_pre_err", bus.illegal_err, 1'b0);
    drive(4'h2, 16'd1, 16'd1, 3'd1);
    tick();
    drive(4'hF, 16'd0, 16'd0, 3'd2);
    tick();
    drive(4'h2, 16'd2, 16'd2, 3'd3);
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    chk("ill_err", bus.illegal_err, 1'b1);
    chk("ill_acc_count", n_acc, 3);
    chk("ill_out_count", n_out, 2);
    chk("ill_res0", qget(0), 16'd2);
    chk("ill_res1", qget(1), 16'd4);
    chk("ill_flags", {bus.flag_z, bus.flag_v, bus.flag_c}, 3'b000);
    repeat (3) tick();
    chk("ill_sticky", bus.illegal_err, 1'b1);

    // Reset with both stages full.
    bus.out_ready = 1'b0;
    drive(4'h2, 16'h8000, 16'h8000, 3'd1);
    tick();
    drive(4'h2, 16'd1, 16'd1, 3'd2);
    tick();
    bus.in_valid = 1'b0;
    chk("mr_full", {bus.out_valid, bus.in_ready}, 2'b10);
    chk("mr_flags_set", {bus.flag_z, bus.flag_v, bus.flag_c}, 3'b111);
    reset = 1'b1;
    #1;
    chk("mr_out_valid", bus.out_valid, 1'b0);
    chk("mr_flags", {bus.flag_z, bus.flag_v, bus.flag_c}, 3'b000);
    chk("mr_err", bus.illegal_err, 1'b0);
    chk("mr_data", {bus.alu_a, bus.out_result}, 32'h0);
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("mr_idle", {bus.out_valid, bus.in_ready}, 2'b01);
    drive(4'h2, 16'd3, 16'd4, 3'd5);
    tick();
    bus.in_valid = 1'b0;
    chk("mr_lat1_valid", bus.out_valid, 1'b0);
    tick();
    chk("mr_lat2_valid", bus.out_valid, 1'b1);
    chk("mr_lat2_data", {bus.out_result, bus.out_dest, bus.out_we}, {16'd7, 3'd5, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
